// File: rtl/rom_download_ctrl_if.sv
// ---------------------------------------------------------------------------
// rom_download_ctrl_if : data_io byte stream and SDRAM toggle-handshake port
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface rom_download_ctrl_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;

  logic        sd_req;
  logic        sd_ack;
  logic [22:0] sd_addr;
  logic [15:0] sd_d;
  logic [1:0]  sd_ds;
  logic        sd_we;

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  sd_ack,
    output sd_req, sd_addr, sd_d, sd_ds, sd_we
  );

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output sd_ack,
    input  sd_req, sd_addr, sd_d, sd_ds, sd_we
  );
endinterface

`default_nettype wire

// File: rtl/rom_download_ctrl.sv
// ---------------------------------------------------------------------------
// rom_download_ctrl : pairs data_io download bytes into 16-bit SDRAM writes
// through a small FIFO and raises rom_loaded once everything is written.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rom_download_ctrl #(
  parameter logic [7:0] ROM_INDEX  = 8'd0,
  parameter int         FIFO_DEPTH = 4
) (
  input  wire logic           clk_sys,
  input  wire logic           reset_n,
  rom_download_ctrl_if.slave  bus,
  output logic                rom_init,
  output logic                busy,
  output logic                rom_loaded,
  output logic                overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 41;   // {addr[22:0], data[15:0], ds[1:0]}

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t       r_state;
  logic         r_wr_d;
  logic         r_rom_init_d;
  logic         r_pend_vld;
  logic [22:0]  r_pend_addr;
  logic [7:0]   r_pend_data;
  logic         r_def_vld;
  logic [22:0]  r_def_addr;
  logic [7:0]   r_def_data;
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic [EW-1:0] r_fifo [FIFO_DEPTH];
  logic         r_sd_req;
  logic [22:0]  r_sd_addr;
  logic [15:0]  r_sd_d;
  logic [1:0]   r_sd_ds;
  logic         r_loaded;
  logic         r_dl_done;
  logic         r_ovf;

  logic         w_accept;
  logic         w_rise;
  logic         w_fall;
  logic [22:0]  w_word;
  logic         w_odd;
  logic         w_full;
  logic         w_empty;
  logic         w_pop;
  logic         w_push;
  logic         w_wr_en;
  logic [EW-1:0] w_push_ent;
  logic [EW-1:0] w_head;
  logic         w_pend_vld_n;
  logic [22:0]  w_pend_addr_n;
  logic [7:0]   w_pend_data_n;
  logic         w_def_vld_n;
  logic [22:0]  w_def_addr_n;
  logic [7:0]   w_def_data_n;
  logic         w_unused;

  assign rom_init = bus.ioctl_download && (bus.ioctl_index == ROM_INDEX);
  assign w_accept = rom_init && bus.ioctl_wr && !r_wr_d;
  assign w_rise   = rom_init && !r_rom_init_d;
  assign w_fall   = !rom_init && r_rom_init_d;
  assign w_word   = bus.ioctl_addr[23:1];
  assign w_odd    = bus.ioctl_addr[0];
  assign w_unused = bus.ioctl_addr[24];

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_head  = r_fifo[r_rd_ptr[AW-1:0]];
  assign w_pop   = (r_state == S_WAIT) && (bus.sd_ack == r_sd_req);
  assign w_wr_en = w_push && !w_full;

  assign busy       = r_pend_vld || r_def_vld || !w_empty || (r_state == S_WAIT);
  assign rom_loaded = r_loaded;
  assign overflow   = r_ovf;

  assign bus.sd_req  = r_sd_req;
  assign bus.sd_addr = r_sd_addr;
  assign bus.sd_d    = r_sd_d;
  assign bus.sd_ds   = r_sd_ds;
  assign bus.sd_we   = rom_init || busy;

  // Byte pairing: decides the single push of this cycle and the next
  // pending/deferred contents. Byte spacing keeps deferred and accept apart.
  always_comb begin
    w_push        = 1'b0;
    w_push_ent    = '0;
    w_pend_vld_n  = r_pend_vld;
    w_pend_addr_n = r_pend_addr;
    w_pend_data_n = r_pend_data;
    w_def_vld_n   = 1'b0;
    w_def_addr_n  = r_def_addr;
    w_def_data_n  = r_def_data;

    if (r_def_vld) begin
      w_push     = 1'b1;
      w_push_ent = {r_def_addr, r_def_data, 8'h00, 2'b10};
    end

    if (w_accept) begin
      if (r_pend_vld && (r_pend_addr != w_word)) begin
        w_push     = 1'b1;
        w_push_ent = {r_pend_addr, 8'h00, r_pend_data, 2'b01};
        if (w_odd) begin
          w_pend_vld_n = 1'b0;
          w_def_vld_n  = 1'b1;
          w_def_addr_n = w_word;
          w_def_data_n = bus.ioctl_dout;
        end else begin
          w_pend_vld_n  = 1'b1;
          w_pend_addr_n = w_word;
          w_pend_data_n = bus.ioctl_dout;
        end
      end else if (!w_odd) begin
        w_pend_vld_n  = 1'b1;
        w_pend_addr_n = w_word;
        w_pend_data_n = bus.ioctl_dout;
      end else begin
        w_push       = 1'b1;
        w_pend_vld_n = 1'b0;
        if (r_pend_vld)
          w_push_ent = {w_word, bus.ioctl_dout, r_pend_data, 2'b11};
        else
          w_push_ent = {w_word, bus.ioctl_dout, 8'h00, 2'b10};
      end
    end else if (w_fall && r_pend_vld) begin
      w_push       = 1'b1;
      w_push_ent   = {r_pend_addr, 8'h00, r_pend_data, 2'b01};
      w_pend_vld_n = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_d       <= 1'b0;
      r_rom_init_d <= 1'b0;
      r_pend_vld   <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_data  <= '0;
      r_def_vld    <= 1'b0;
      r_def_addr   <= '0;
      r_def_data   <= '0;
    end else begin
      r_wr_d       <= bus.ioctl_wr;
      r_rom_init_d <= rom_init;
      r_pend_vld   <= w_pend_vld_n;
      r_pend_addr  <= w_pend_addr_n;
      r_pend_data  <= w_pend_data_n;
      r_def_vld    <= w_def_vld_n;
      r_def_addr   <= w_def_addr_n;
      r_def_data   <= w_def_data_n;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (w_wr_en)
      r_fifo[r_wr_ptr[AW-1:0]] <= w_push_ent;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, w_wr_en};
      r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, w_pop};
      // A drop in the same cycle as a new download start still counts.
      if (w_push && w_full)
        r_ovf <= 1'b1;
      else if (w_rise)
        r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_sd_req  <= 1'b0;
      r_sd_addr <= '0;
      r_sd_d    <= '0;
      r_sd_ds   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_sd_addr <= w_head[40:18];
            r_sd_d    <= w_head[17:2];
            r_sd_ds   <= w_head[1:0];
            r_sd_req  <= !r_sd_req;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.sd_ack == r_sd_req)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_loaded  <= 1'b0;
      r_dl_done <= 1'b0;
    end else if (w_rise) begin
      r_loaded  <= 1'b0;
      r_dl_done <= 1'b0;
    end else begin
      if (w_fall)
        r_dl_done <= 1'b1;
      if ((r_dl_done || w_fall) && !rom_init && !busy && !r_ovf)
        r_loaded <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rom_download_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rom_download_ctrl : randomized scoreboard bench for rom_download_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rom_download_ctrl;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rom_init, busy, rom_loaded, overflow;

  rom_download_ctrl_if bus ();

  rom_download_ctrl #(.ROM_INDEX(8'd0), .FIFO_DEPTH(DEPTH)) dut (
    .clk_sys   (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .rom_init  (rom_init),
    .busy      (busy),
    .rom_loaded(rom_loaded),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int req_cnt = 0;
  bit hold    = 1'b0;

  logic [40:0] exp_q[$];

  // Reference model state: one byte waiting for its partner word byte.
  bit          m_pend;
  logic [22:0] m_paddr;
  logic [7:0]  m_pdata;
  bit          m_rom;
  bit          exp_ovf;
  bit          bp_mode;
  int          bp_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic m_push(input logic [22:0] a, input logic [15:0] d, input logic [1:0] ds);
    if (bp_mode) begin
      bp_cnt++;
      if (bp_cnt > DEPTH) begin
        exp_ovf = 1'b1;
        return;
      end
    end
    exp_q.push_back({a, d, ds});
  endtask

  task automatic m_byte(input logic [23:0] a, input logic [7:0] d);
    logic [22:0] w;
    w = a[23:1];
    if (m_pend && m_paddr != w) begin
      m_push(m_paddr, {8'h00, m_pdata}, 2'b01);
      m_pend = 1'b0;
      if (a[0]) m_push(w, {d, 8'h00}, 2'b10);
      else begin m_pend = 1'b1; m_paddr = w; m_pdata = d; end
    end else if (!a[0]) begin
      m_pend = 1'b1; m_paddr = w; m_pdata = d;
    end else if (m_pend) begin
      m_push(w, {d, m_pdata}, 2'b11);
      m_pend = 1'b0;
    end else begin
      m_push(w, {d, 8'h00}, 2'b10);
    end
  endtask

  task automatic start_dl(input logic [7:0] idx);
    bus.ioctl_download = 1'b1;
    bus.ioctl_index    = idx;
    m_rom = (idx == 8'd0);
    if (m_rom) exp_ovf = 1'b0;
    tick(1);
    chk("rom_init_on", rom_init, m_rom);
  endtask

  task automatic end_dl();
    bus.ioctl_download = 1'b0;
    if (m_rom && m_pend) begin
      m_push(m_paddr, {8'h00, m_pdata}, 2'b01);
      m_pend = 1'b0;
    end
    m_rom = 1'b0;
    tick(1);
    chk("rom_init_off", rom_init, 1'b0);
  endtask

  task automatic send_byte(input logic [23:0] a, input logic [7:0] d, input int gap);
    bus.ioctl_addr = {1'($urandom_range(0, 1)), a};
    bus.ioctl_dout = d;
    bus.ioctl_wr   = 1'b1;
    if (m_rom) m_byte(a, d);
    tick(1);
    bus.ioctl_wr = 1'b0;
    tick(gap - 1);
  endtask

  task automatic wait_idle(input int budget, input bit exp_loaded);
    int k = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && k < budget) begin
      tick(1);
      k++;
    end
    chk("idle_timeout", (k < budget), 1'b1);
    tick(1);
    chk("rom_loaded", rom_loaded, exp_loaded);
    chk("overflow", overflow, exp_ovf);
  endtask

  // SDRAM side: answer each toggle after a short random latency.
  always @(negedge clk) begin
    static int lat = 0;
    if (!reset_n) begin
      bus.sd_ack = 1'b0;
      lat = 0;
    end else if (!hold && bus.sd_req != bus.sd_ack) begin
      if (lat == 0) begin
        bus.sd_ack = bus.sd_req;
        lat = $urandom_range(0, 2);
      end else begin
        lat--;
      end
    end
  end

  // Monitor: every sd_req toggle is one write checked against the queue.
  always @(negedge clk) begin
    static logic prev = 1'b0;
    logic [40:0] e;
    if (!reset_n) begin
      prev = 1'b0;
    end else if (bus.sd_req !== prev) begin
      prev = bus.sd_req;
      req_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {bus.sd_addr, bus.sd_d, bus.sd_ds}, 41'h0);
        if ({bus.sd_addr, bus.sd_d, bus.sd_ds} == 41'h0) begin
          n_fail++;
          $display("FAIL unexpected_write: got empty-queue write, expected none");
        end
      end else begin
        e = exp_q.pop_front();
        chk("sd_write", {bus.sd_addr, bus.sd_d, bus.sd_ds}, e);
        chk("sd_we", bus.sd_we, 1'b1);
      end
    end
  end

  initial begin
    int rc;
    logic [23:0] a;
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    m_pend = 0; m_rom = 0; exp_ovf = 0; bp_mode = 0; bp_cnt = 0;

    tick(3);
    chk("rst_sd_req", bus.sd_req, 1'b0);
    chk("rst_sd_addr", bus.sd_addr, 23'h0);
    chk("rst_sd_d", bus.sd_d, 16'h0);
    chk("rst_sd_ds", bus.sd_ds, 2'b00);
    chk("rst_loaded", rom_loaded, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset_n = 1'b1;
    tick(2);

    // Sequential bytes
    start_dl(8'd0);
    chk("loaded_clear", rom_loaded, 1'b0);
    send_byte(24'd0, 8'h11, 6);
    send_byte(24'd1, 8'h22, 6);
    send_byte(24'd2, 8'h33, 6);
    send_byte(24'd3, 8'h44, 6);
    end_dl();
    wait_idle(500, 1'b1);

    // Odd-length download
    start_dl(8'd0);
    send_byte(24'd0, 8'hAA, 6);
    send_byte(24'd1, 8'hBB, 6);
    send_byte(24'd2, 8'hCC, 6);
    end_dl();
    wait_idle(500, 1'b1);

    // Address gap: partial low word, then deferred high byte
    start_dl(8'd0);
    send_byte(24'h10, 8'h5A, 6);
    send_byte(24'h21, 8'hA5, 6);
    end_dl();
    wait_idle(500, 1'b1);

    // Randomized downloads with sequential runs and random jumps
    for (int d = 0; d < 4; d++) begin
      start_dl(8'd0);
      a = 24'($urandom) & 24'hFFFFF0;
      for (int i = 0; i < int'($urandom_range(3, 14)); i++) begin
        if ($urandom_range(0, 4) == 0) a = 24'($urandom);
        send_byte(a, 8'($urandom), $urandom_range(6, 10));
        a = a + 24'd1;
      end
      end_dl();
      wait_idle(1000, 1'b1);
    end

    // Index filter
    rc = req_cnt;
    start_dl(8'd1);
    for (int i = 0; i < 4; i++) send_byte(24'(i), 8'($urandom), 6);
    end_dl();
    tick(20);
    chk("filter_req", req_cnt, rc);
    chk("filter_loaded", rom_loaded, 1'b1);

    // Back-pressure: ack withheld while 12 bytes arrive
    hold = 1'b1;
    bp_mode = 1'b1;
    bp_cnt = 0;
    start_dl(8'd0);
    for (int i = 0; i < 12; i++) send_byte(24'(i), 8'(8'h30 + i), 4);
    end_dl();
    chk("bp_ovf_set", overflow, 1'b1);
    tick(200 - 50);
    chk("bp_loaded_low", rom_loaded, 1'b0);
    hold = 1'b0;
    bp_mode = 1'b0;
    wait_idle(500, 1'b0);

    start_dl(8'd0);
    chk("ovf_cleared", overflow, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(24'(i + 8), 8'($urandom), 6);
    end_dl();
    wait_idle(500, 1'b1);

    // Reset while a request is outstanding
    hold = 1'b1;
    start_dl(8'd0);
    send_byte(24'd0, 8'h12, 6);
    send_byte(24'd1, 8'h34, 6);
    chk("rst_pre_busy", busy, 1'b1);
    bus.ioctl_download = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_sd_req", bus.sd_req, 1'b0);
    chk("mid_rst_sd_addr", bus.sd_addr, 23'h0);
    chk("mid_rst_sd_d", bus.sd_d, 16'h0);
    chk("mid_rst_sd_ds", bus.sd_ds, 2'b00);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_we", bus.sd_we, 1'b0);
    chk("mid_rst_loaded", rom_loaded, 1'b0);
    exp_q.delete();
    m_pend = 1'b0;
    m_rom = 1'b0;
    exp_ovf = 1'b0;
    tick(1);
    reset_n = 1'b1;
    hold = 1'b0;
    tick(2);
    start_dl(8'd0);
    send_byte(24'h40, 8'hDE, 6);
    send_byte(24'h41, 8'hAD, 6);
    send_byte(24'h42, 8'hBE, 6);
    end_dl();
    wait_idle(500, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire
